// File: rtl/skid_rr_arbiter_pkg.sv
// Shared constants and helpers for the skid-buffered round-robin FIFO arbiter.
package skid_rr_arbiter_pkg;

  localparam int MIN_PORTS = 2;
  localparam int MAX_PORTS = 8;
  localparam int BUF_DEPTH = 3;

  // Next index in round-robin order, wrapping at num_ports.
  function automatic int rr_next(input int idx, input int num_ports);
    return (idx + 1 >= num_ports) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/skid_rr_arbiter_if.sv
// Upstream FIFO read bundle plus downstream valid/ready stream of the arbiter.
interface skid_rr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int SRC_WIDTH  = 2
);

  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data;
  logic [NUM_PORTS-1:0]            fifo_empty;
  logic [NUM_PORTS-1:0]            fifo_pop;
  logic [NUM_PORTS-1:0]            port_en;
  logic [DATA_WIDTH-1:0]           dn_bus;
  logic [SRC_WIDTH-1:0]            dn_src;
  logic                            dn_val;
  logic                            dn_rdy;

  // Arbiter side.
  modport master (
    input  fifo_data, fifo_empty, port_en, dn_rdy,
    output fifo_pop, dn_bus, dn_src, dn_val
  );

  // FIFO / downstream environment side.
  modport slave (
    output fifo_data, fifo_empty, port_en, dn_rdy,
    input  fifo_pop, dn_bus, dn_src, dn_val
  );

endinterface

// File: rtl/skid_rr_arbiter_rr_pick.sv
// Combinational rotate-priority pick: first candidate after last_grant, wrapping.
module skid_rr_arbiter_rr_pick
  import skid_rr_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int SRC_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0] cand,
  input  logic [SRC_WIDTH-1:0] last_grant,
  output logic                 grant_vld,
  output logic [SRC_WIDTH-1:0] grant_idx
);

  int                   idx;
  logic [NUM_PORTS-1:0] cand_sh;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sh   = '0;
    idx       = int'(last_grant);
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx     = rr_next(idx, NUM_PORTS);
      cand_sh = cand >> idx;
      if (!grant_vld && cand_sh[0]) begin
        grant_vld = 1'b1;
        grant_idx = SRC_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/skid_rr_arbiter.sv
// Round-robin arbiter over NUM_PORTS one-cycle-latency FIFOs feeding a
// 3-entry in-order skid buffer with a valid/ready downstream port.
module skid_rr_arbiter
  import skid_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int SRC_WIDTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  skid_rr_arbiter_if.master bus
);

  if (NUM_PORTS < MIN_PORTS || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("skid_rr_arbiter: NUM_PORTS out of range");
  end
  if (SRC_WIDTH != $clog2(NUM_PORTS)) begin : g_bad_src
    $error("skid_rr_arbiter: SRC_WIDTH must equal clog2(NUM_PORTS)");
  end

  logic [NUM_PORTS-1:0]  cand;
  logic                  grant_vld;
  logic [SRC_WIDTH-1:0]  grant_idx;
  logic [SRC_WIDTH-1:0]  last_grant;
  logic                  room;
  logic                  pop_go;
  logic                  retire;
  logic [1:0]            wr_slot;
  logic [DATA_WIDTH-1:0] cap_word;

  // p0: pop issued, FIFO word arriving next cycle.
  logic                  vld_p0;
  logic [SRC_WIDTH-1:0]  src_p0;

  // p1: buffered words, entry 0 is the head.
  logic [1:0]            occ_p1;
  logic [DATA_WIDTH-1:0] data_p1 [BUF_DEPTH];
  logic [SRC_WIDTH-1:0]  src_p1  [BUF_DEPTH];

  assign cand = ~bus.fifo_empty & bus.port_en;

  skid_rr_arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .SRC_WIDTH (SRC_WIDTH)
  ) rr_pick (
    .cand       (cand),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant_idx  (grant_idx)
  );

  // Reserve a slot for every word already committed, so a stalled head never overflows.
  assign room         = ({1'b0, occ_p1} + {2'b00, vld_p0}) <= 3'(BUF_DEPTH - 1);
  assign pop_go       = rst_n & room & grant_vld;
  assign bus.fifo_pop = pop_go ? (NUM_PORTS'(1) << grant_idx) : '0;

  assign retire   = bus.dn_val & bus.dn_rdy;
  assign wr_slot  = occ_p1 - {1'b0, retire};
  assign cap_word = bus.fifo_data[int'(src_p0)*DATA_WIDTH +: DATA_WIDTH];

  assign bus.dn_val = (occ_p1 != 2'd0);
  assign bus.dn_bus = data_p1[0];
  assign bus.dn_src = src_p1[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      occ_p1     <= 2'd0;
      last_grant <= SRC_WIDTH'(NUM_PORTS - 1);
    end else begin
      vld_p0 <= pop_go;
      occ_p1 <= occ_p1 + {1'b0, vld_p0} - {1'b0, retire};
      if (pop_go) begin
        last_grant <= grant_idx;
      end
    end
  end

  // Retire shifts the queue down; a capture then lands just past the surviving words.
  always_ff @(posedge clk) begin
    if (pop_go) begin
      src_p0 <= grant_idx;
    end
    for (int i = 0; i < BUF_DEPTH - 1; i++) begin
      if (retire) begin
        data_p1[i] <= data_p1[i+1];
        src_p1[i]  <= src_p1[i+1];
      end
    end
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (vld_p0 && wr_slot == 2'(i)) begin
        data_p1[i] <= cap_word;
        src_p1[i]  <= src_p0;
      end
    end
  end

endmodule

// File: tb/tb_skid_rr_arbiter.sv
// Bench for skid_rr_arbiter: queue-based FIFO environment, scoreboard model, directed and random phases.
module tb_skid_rr_arbiter;

  localparam int DW = 32;
  localparam int NP = 4;
  localparam int SW = 2;

  typedef struct {
    logic [DW-1:0] w;
    int            src;
    int            cyc;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  skid_rr_arbiter_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .SRC_WIDTH(SW)) bif ();

  skid_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .SRC_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int total = 0;
  int bad = 0;

  logic [DW-1:0] srcq [NP][$];
  ent_t          sb[$];
  int            last_g = NP - 1;
  int            cyc = 0;
  int            wcnt = 0;
  int            delivered = 0;
  logic [NP-1:0] en = '1;
  logic [NP-1:0] mask = '0;
  logic          rdy = 1'b0;

  logic [NP-1:0] obs_pop[$];
  logic          obs_val[$];
  logic [DW-1:0] obs_bus[$];
  logic [SW-1:0] obs_src[$];

  int            exp_src2[6] = '{0, 1, 2, 3, 0, 1};
  int            exp_src4[4] = '{0, 1, 3, 0};
  logic [DW-1:0] w3[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] new_word(input int p);
    wcnt++;
    return {4'(p), 28'(wcnt)};
  endfunction

  task automatic fill(input int p, input int n);
    repeat (n) srcq[p].push_back(new_word(p));
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NP; i++) srcq[i].delete();
  endtask

  task automatic clear_log();
    obs_pop.delete(); obs_val.delete(); obs_bus.delete(); obs_src.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) bif.fifo_empty[i] = (srcq[i].size() == 0) || mask[i];
    bif.port_en = en;
    bif.dn_rdy  = rdy;
  endtask

  // One clock: check DUT against the model at the negedge, then advance model and FIFOs.
  task automatic step();
    logic [NP-1:0] exp_pop;
    logic [NP-1:0] got_pop;
    logic          exp_val;
    int            idx;
    ent_t          e;
    drive();
    @(negedge clk);
    exp_pop = '0;
    idx = last_g;
    if (sb.size() <= 2) begin
      for (int k = 0; k < NP; k++) begin
        idx = (idx + 1) % NP;
        if (srcq[idx].size() != 0 && !mask[idx] && en[idx]) begin
          exp_pop[idx] = 1'b1;
          break;
        end
      end
    end
    got_pop = bif.fifo_pop;
    chk("fifo_pop", 64'(got_pop), 64'(exp_pop));
    exp_val = 1'b0;
    if (sb.size() != 0) exp_val = (sb[0].cyc <= cyc - 2);
    chk("dn_val", 64'(bif.dn_val), 64'(exp_val));
    if (exp_val) begin
      chk("dn_bus", 64'(bif.dn_bus), 64'(sb[0].w));
      chk("dn_src", 64'(bif.dn_src), 64'(sb[0].src));
    end
    obs_pop.push_back(got_pop);
    obs_val.push_back(bif.dn_val);
    obs_bus.push_back(bif.dn_bus);
    obs_src.push_back(bif.dn_src);
    if (exp_val && rdy) begin
      void'(sb.pop_front());
      delivered++;
    end
    if (exp_pop != '0) begin
      e.w = srcq[idx][0];
      e.src = idx;
      e.cyc = cyc;
      sb.push_back(e);
      last_g = idx;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NP; i++) begin
      if (got_pop[i] && srcq[i].size() != 0) bif.fifo_data[i*DW +: DW] = srcq[i].pop_front();
      else bif.fifo_data[i*DW +: DW] = $urandom();
    end
  endtask

  task automatic do_reset();
    drive();
    rst_n = 1'b0;
    #1;
    chk("rst_pop", 64'(bif.fifo_pop), 64'(0));
    chk("rst_val", 64'(bif.dn_val), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    last_g = NP - 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bif.fifo_data  = '0;
    bif.fifo_empty = '1;
    bif.port_en    = '1;
    bif.dn_rdy     = 1'b0;

    // Reset held with every FIFO non-empty.
    for (int p = 0; p < NP; p++) fill(p, 2);
    drive();
    @(posedge clk); #1;
    chk("init_rst_pop", 64'(bif.fifo_pop), 64'(0));
    chk("init_rst_val", 64'(bif.dn_val), 64'(0));
    @(posedge clk); #1;
    clear_srcs();
    srcq[2].push_back(32'hA000_000A);
    srcq[2].push_back(32'hB000_000B);
    srcq[2].push_back(32'hC000_000C);
    rst_n = 1'b1;

    // Port 2 alone with A,B,C.
    rdy = 1'b1; en = '1; clear_log();
    repeat (6) step();
    chk("p1_pop0", 64'(obs_pop[0]), 64'(4'b0100));
    chk("p1_pop1", 64'(obs_pop[1]), 64'(4'b0100));
    chk("p1_pop2", 64'(obs_pop[2]), 64'(4'b0100));
    chk("p1_pop3", 64'(obs_pop[3]), 64'(0));
    chk("p1_val1", 64'(obs_val[1]), 64'(0));
    chk("p1_bus2", 64'(obs_bus[2]), 64'(32'hA000_000A));
    chk("p1_bus3", 64'(obs_bus[3]), 64'(32'hB000_000B));
    chk("p1_bus4", 64'(obs_bus[4]), 64'(32'hC000_000C));
    for (int c = 2; c <= 4; c++) chk("p1_src", 64'(obs_src[c]), 64'(2));
    chk("p1_val5", 64'(obs_val[5]), 64'(0));

    // All ports busy: rotation and one word per cycle.
    do_reset();
    for (int p = 0; p < NP; p++) fill(p, 12);
    clear_log();
    repeat (10) step();
    for (int c = 0; c < 6; c++) chk("p2_src", 64'(obs_src[c+2]), 64'(exp_src2[c]));
    for (int c = 2; c < 10; c++) chk("p2_val", 64'(obs_val[c]), 64'(1));

    // Stalled downstream: exactly three pops, stable head, gapless drain.
    do_reset();
    clear_srcs();
    fill(0, 20);
    for (int k = 0; k < 4; k++) w3[k] = srcq[0][k];
    rdy = 1'b0; clear_log();
    repeat (5) step();
    rdy = 1'b1;
    repeat (6) step();
    n = 0;
    for (int c = 0; c < 5; c++) n += $countones(obs_pop[c]);
    chk("p3_pops", 64'(n), 64'(3));
    chk("p3_pop3", 64'(obs_pop[3]), 64'(0));
    chk("p3_pop4", 64'(obs_pop[4]), 64'(0));
    for (int c = 2; c <= 4; c++) chk("p3_stall_bus", 64'(obs_bus[c]), 64'(w3[0]));
    for (int c = 5; c <= 8; c++) begin
      chk("p3_drain_val", 64'(obs_val[c]), 64'(1));
      chk("p3_drain_bus", 64'(obs_bus[c]), 64'(w3[c-5]));
    end

    // Port 2 disabled.
    do_reset();
    clear_srcs();
    for (int p = 0; p < NP; p++) fill(p, 12);
    en = 4'b1011; clear_log();
    repeat (12) step();
    for (int c = 0; c < 4; c++) chk("p4_src", 64'(obs_src[c+2]), 64'(exp_src4[c]));
    n = 0;
    for (int c = 0; c < 12; c++) if (obs_val[c] && obs_src[c] == 2'd2) n++;
    chk("p4_no_port2", 64'(n), 64'(0));

    // Random empty flags, ready and enables.
    do_reset();
    clear_srcs();
    en = '1; delivered = 0;
    for (int t = 0; t < 10000; t++) begin
      if (t % 1000 == 999) en = NP'($urandom_range(1, (1 << NP) - 1));
      mask = NP'($urandom() & $urandom());
      rdy  = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NP; p++)
        if (srcq[p].size() < 3 && $urandom_range(0, 1) == 1) fill(p, 1 + $urandom_range(0, 3));
      clear_log();
      step();
    end
    clear_srcs();
    mask = '0; rdy = 1'b1; en = '1;
    repeat (8) step();
    chk("p5_drained", 64'(sb.size()), 64'(0));
    chk("p5_delivered", 64'(delivered > 2000), 64'(1));

    // Asynchronous reset with words buffered and one in flight.
    do_reset();
    clear_srcs();
    for (int p = 0; p < NP; p++) fill(p, 4);
    en = '1; rdy = 1'b0;
    repeat (3) step();
    chk("p6_pre_val", 64'(bif.dn_val), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("p6_rst_val", 64'(bif.dn_val), 64'(0));
    chk("p6_rst_pop", 64'(bif.fifo_pop), 64'(0));
    @(negedge clk);
    chk("p6_rst_pop_hold", 64'(bif.fifo_pop), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    last_g = NP - 1;
    clear_log();
    step();
    chk("p6_first_grant", 64'(obs_pop[0]), 64'(4'b0001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
